// File: rtl/step_run_controller.sv
// Clock-enable sequencer for the pipelined core: halt, single step, fixed burst
// and divided free-run, with a PC breakpoint that parks the core in BREAK.
module step_run_controller #(
  parameter int RUN_DIV   = 5000000,
  parameter int DIV_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_req,
  input  logic [1:0]  mode,
  input  logic [7:0]  burst_len,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_en,
  output logic        halted,
  output logic        busy,
  output logic        bp_hit,
  output logic [15:0] step_count
);

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_RUN   = 2'b11;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_BURST,
    S_RUN,
    S_BREAK
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_cpu_en, w_cpu_en_nxt;
  logic                 r_bp_hit, w_bp_hit_nxt;
  logic [7:0]           r_remaining, w_remaining_nxt;
  logic [DIV_WIDTH-1:0] r_div, w_div_nxt;
  logic                 r_gap, w_gap_nxt;
  logic [15:0]          r_step_count;
  logic                 w_bp_match;

  assign w_bp_match = bp_en && (pc == bp_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cpu_en     <= 1'b0;
      r_bp_hit     <= 1'b0;
      r_remaining  <= '0;
      r_div        <= '0;
      r_gap        <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_en    <= w_cpu_en_nxt;
      r_bp_hit    <= w_bp_hit_nxt;
      r_remaining <= w_remaining_nxt;
      r_div       <= w_div_nxt;
      r_gap       <= w_gap_nxt;
      if (r_cpu_en) r_step_count <= r_step_count + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cpu_en_nxt    = 1'b0;
    w_bp_hit_nxt    = r_bp_hit;
    w_remaining_nxt = r_remaining;
    w_div_nxt       = r_div;
    w_gap_nxt       = 1'b0;
    if (mode == MODE_HALT) begin
      w_state_nxt  = S_IDLE;
      w_bp_hit_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mode == MODE_RUN) begin
            w_state_nxt = S_RUN;
            w_div_nxt   = '0;
          end else if (step_req && mode == MODE_STEP) begin
            w_state_nxt = S_STEP;
          end else if (step_req && mode == MODE_BURST && burst_len != 8'd0) begin
            w_state_nxt     = S_BURST;
            w_remaining_nxt = burst_len;
          end
        end
        S_STEP: begin
          w_cpu_en_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end
        // Decision cycles alternate with gap cycles so pc has updated before each check.
        S_BURST: begin
          if (!r_gap) begin
            if (w_bp_match) begin
              w_state_nxt  = S_BREAK;
              w_bp_hit_nxt = 1'b1;
            end else begin
              w_cpu_en_nxt    = 1'b1;
              w_remaining_nxt = r_remaining - 8'd1;
              if (r_remaining == 8'd1) w_state_nxt = S_IDLE;
              else                     w_gap_nxt   = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (mode != MODE_RUN) begin
            w_state_nxt = S_IDLE;
          end else if (r_div == DIV_LAST) begin
            w_div_nxt = '0;
            if (w_bp_match) begin
              w_state_nxt  = S_BREAK;
              w_bp_hit_nxt = 1'b1;
            end else begin
              w_cpu_en_nxt = 1'b1;
            end
          end else begin
            w_div_nxt = r_div + 1'b1;
          end
        end
        S_BREAK: begin
          if (step_req && mode == MODE_STEP) begin
            w_state_nxt  = S_STEP;
            w_bp_hit_nxt = 1'b0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign cpu_en     = r_cpu_en;
  assign bp_hit     = r_bp_hit;
  assign step_count = r_step_count;
  assign halted     = (r_state == S_IDLE) || (r_state == S_BREAK);
  assign busy       = (r_state == S_STEP) || (r_state == S_BURST) || (r_state == S_RUN);

endmodule

// File: tb/tb_step_run_controller.sv
// Scoreboard bench: expected cpu_en pulse cycles are queued when stimulus is
// driven and matched against each observed pulse.
module tb_step_run_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_req = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  burst_len = 8'd0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        cpu_en, halted, busy, bp_hit;
  logic [15:0] step_count;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  step_run_controller #(.RUN_DIV(4), .DIV_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .step_req(step_req), .mode(mode),
    .burst_len(burst_len), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .halted(halted), .busy(busy), .bp_hit(bp_hit),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Processor model: pc advances one word per enabled cycle.
  always @(posedge clk) begin
    if (reset)       pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_en === 1'b1) begin
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("pulse_cycle", cyc, e);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step_req = 1'b0;
    mode = 2'b00;
    bp_en = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
  endtask

  task automatic queue_done(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  int unsigned k;

  initial begin
    // Reset state
    do_reset();
    check("rst_cpu_en", cpu_en, 0);
    check("rst_count", step_count, 0);
    check("rst_halted", halted, 1);
    check("rst_busy", busy, 0);
    check("rst_bp_hit", bp_hit, 0);

    // Single step: pulse two cycles after the step_req edge
    mode = 2'b01;
    tick(3);
    k = cyc;
    exp_q.push_back(k + 2);
    pulse_step();
    check("step_busy", busy, 1);
    check("step_halted", halted, 0);
    tick(5);
    check("step_count", step_count, 1);
    check("step_halted_after", halted, 1);
    queue_done("step_missing");

    // Burst of 4, no breakpoint
    do_reset();
    mode = 2'b10;
    burst_len = 8'd4;
    tick(1);
    k = cyc;
    for (int i = 0; i < 4; i++) exp_q.push_back(k + 2 + 2 * i);
    pulse_step();
    tick(14);
    check("burst4_count", step_count, 4);
    check("burst4_halted", halted, 1);
    check("burst4_busy", busy, 0);
    queue_done("burst4_missing");

    // Burst length zero does nothing
    burst_len = 8'd0;
    pulse_step();
    tick(6);
    check("burst0_count", step_count, 4);
    check("burst0_busy", busy, 0);

    // Burst of 10 with breakpoint at 0x0C: 3 pulses then BREAK
    do_reset();
    mode = 2'b10;
    burst_len = 8'd10;
    bp_en = 1'b1;
    bp_addr = 32'h0C;
    tick(1);
    k = cyc;
    for (int i = 0; i < 3; i++) exp_q.push_back(k + 2 + 2 * i);
    pulse_step();
    tick(16);
    check("bp_count", step_count, 3);
    check("bp_hit_set", bp_hit, 1);
    check("bp_halted", halted, 1);
    check("bp_pc", pc, 32'h0C);
    queue_done("bp_missing");
    // Burst/run modes must not restart from BREAK
    pulse_step();
    mode = 2'b11;
    tick(12);
    check("bp_stuck_count", step_count, 3);
    check("bp_stuck_hit", bp_hit, 1);
    // Single step past the breakpoint
    mode = 2'b01;
    tick(1);
    k = cyc;
    exp_q.push_back(k + 2);
    pulse_step();
    check("bp_clear", bp_hit, 0);
    tick(5);
    check("bp_step_count", step_count, 4);
    check("bp_step_halted", halted, 1);
    queue_done("bp_step_missing");

    // Run at RUN_DIV=4: five pulses, then mode 00 mid-count
    do_reset();
    tick(1);
    k = cyc;
    for (int i = 0; i < 5; i++) exp_q.push_back(k + 5 + 4 * i);
    mode = 2'b11;
    tick(22);
    check("run_busy", busy, 1);
    mode = 2'b00;
    tick(15);
    check("run_count", step_count, 5);
    check("run_halted", halted, 1);
    queue_done("run_missing");

    // Run hitting a breakpoint at 0x08: two pulses, then BREAK; mode 00 clears
    do_reset();
    bp_en = 1'b1;
    bp_addr = 32'h08;
    tick(1);
    k = cyc;
    exp_q.push_back(k + 5);
    exp_q.push_back(k + 9);
    mode = 2'b11;
    tick(25);
    check("runbp_count", step_count, 2);
    check("runbp_hit", bp_hit, 1);
    check("runbp_halted", halted, 1);
    mode = 2'b00;
    tick(2);
    check("runbp_cleared", bp_hit, 0);
    queue_done("runbp_missing");

    // Reset during a burst of 8 after the second pulse
    do_reset();
    mode = 2'b10;
    burst_len = 8'd8;
    tick(1);
    k = cyc;
    exp_q.push_back(k + 2);
    exp_q.push_back(k + 4);
    pulse_step();
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort_count", step_count, 0);
    check("abort_bp_hit", bp_hit, 0);
    check("abort_halted", halted, 1);
    tick(20);
    check("abort_count_later", step_count, 0);
    queue_done("abort_missing");

    // step_count wraps FFFF -> 0000
    do_reset();
    mode = 2'b01;
    tick(1);
    force dut.r_step_count = 16'hFFFF;
    tick(1);
    release dut.r_step_count;
    tick(1);
    check("wrap_preload", step_count, 16'hFFFF);
    k = cyc;
    exp_q.push_back(k + 2);
    pulse_step();
    tick(5);
    check("wrap_count", step_count, 16'h0000);
    queue_done("wrap_missing");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
